// File: rtl/hamming_enc_stream.sv
// rtl/hamming_enc_stream.sv - streaming Hamming SEC encoder with a 2-entry output buffer
// Define HAMMING_SECDED_EN to append an overall even-parity bit (SECDED codewords).
module hamming_enc_stream #(
    parameter int DATA_W = 16,
    // smallest r with 2**r >= DATA_W+r+1 (closed form for DATA_W up to 120)
    localparam int PAR_W = (DATA_W <= 4)  ? 3 :
                           (DATA_W <= 11) ? 4 :
                           (DATA_W <= 26) ? 5 :
                           (DATA_W <= 57) ? 6 : 7,
    localparam int SEC_W = DATA_W + PAR_W,
`ifdef HAMMING_SECDED_EN
    localparam int CODE_W = SEC_W + 1
`else
    localparam int CODE_W = SEC_W
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] iData,
    input  logic              iValid,
    output logic              oReady,
    output logic [CODE_W-1:0] oData,
    output logic              oValid,
    input  logic              iReady
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CODE_W-1:0] code_word;
    logic [CODE_W-1:0] head;
    logic [CODE_W-1:0] tail;
    logic              push;
    logic              pop;
    logic              load_head_new;
    logic              load_tail;
    logic              head_from_tail;

    function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c;
        logic              p;
        int                k;
        c = '0;
        k = 0;
        for (int pos = 1; pos <= SEC_W; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos-1] = d[k];
                k++;
            end
        end
        // parity slots are still zero here and never cover each other
        for (int i = 0; i < PAR_W; i++) begin
            p = 1'b0;
            for (int pos = 1; pos <= SEC_W; pos++) begin
                if (((pos >> i) & 1) != 0) begin
                    p = p ^ c[pos-1];
                end
            end
            c[(1 << i) - 1] = p;
        end
`ifdef HAMMING_SECDED_EN
        c[CODE_W-1] = ^c[SEC_W-1:0];
`endif
        return c;
    endfunction

    always_comb begin
        code_word = encode(iData);
    end

    assign oReady = rst & (state != FULL);
    assign oValid = (state != EMPTY);
    assign oData  = head;
    assign push   = iValid & oReady;
    assign pop    = oValid & iReady;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        load_head_new  = 1'b0;
        load_tail      = 1'b0;
        head_from_tail = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    load_head_new = 1'b1;
                    state_next    = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    load_head_new = 1'b1;
                end else if (push) begin
                    load_tail  = 1'b1;
                    state_next = FULL;
                end else if (pop) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    head_from_tail = 1'b1;
                    state_next     = ONE;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (load_head_new) begin
                head <= code_word;
            end else if (head_from_tail) begin
                head <= tail;
            end
            if (load_tail) begin
                tail <= code_word;
            end
        end
    end

endmodule

// File: tb/tb_hamming_enc_stream.sv
// tb/tb_hamming_enc_stream.sv - self-checking bench for hamming_enc_stream (honours HAMMING_SECDED_EN)
module tb_hamming_enc_stream;

    localparam int DATA_W = 16;

    function automatic int calc_par(input int dw);
        int r;
        r = 1;
        while ((1 << r) < dw + r + 1) r++;
        return r;
    endfunction

    localparam int PAR_W = calc_par(DATA_W);
    localparam int SEC_W = DATA_W + PAR_W;
`ifdef HAMMING_SECDED_EN
    localparam int CODE_W = SEC_W + 1;
`else
    localparam int CODE_W = SEC_W;
`endif

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] iData;
    logic              iValid;
    logic              oReady;
    logic [CODE_W-1:0] oData;
    logic              oValid;
    logic              iReady;

    int errors;
    int checks;
    int popped;
    logic [CODE_W-1:0] q[$];

    hamming_enc_stream #(.DATA_W(DATA_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .iData  (iData),
        .iValid (iValid),
        .oReady (oReady),
        .oData  (oData),
        .oValid (oValid),
        .iReady (iReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Parity bits are the binary digits of the XOR of positions holding a 1 data bit
    function automatic logic [CODE_W-1:0] ref_encode(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c;
        int pos;
        int syn;
        c = '0;
        pos = 1;
        syn = 0;
        for (int k = 0; k < DATA_W; k++) begin
            while ((pos & (pos - 1)) == 0) pos++;
            if (d[k]) begin
                c[pos-1] = 1'b1;
                syn = syn ^ pos;
            end
            pos++;
        end
        for (int i = 0; i < PAR_W; i++) c[(1 << i) - 1] = syn[i];
`ifdef HAMMING_SECDED_EN
        c[CODE_W-1] = ^c[SEC_W-1:0];
`endif
        return c;
    endfunction

    function automatic int syndrome(input logic [CODE_W-1:0] cw);
        int s;
        s = 0;
        for (int b = 0; b < SEC_W; b++) if (cw[b]) s = s ^ (b + 1);
        return s;
    endfunction

    function automatic int flip_faults(input logic [CODE_W-1:0] cw);
        logic [CODE_W-1:0] f;
        int bad;
        bad = 0;
        for (int b = 0; b < CODE_W; b++) begin
            f = cw;
            f[b] = ~f[b];
            if (b < SEC_W) begin
                if (syndrome(f) != b + 1) bad++;
            end else if ((^f) != 1'b1) begin
                bad++;
            end
        end
        return bad;
    endfunction

    task automatic run_random(input int n, input int pv, input int pr, input bit stream);
        logic [DATA_W-1:0] d;
        bit iv;
        bit ir;
        bit do_pop;
        bit do_push;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            check("rnd_valid", 64'(oValid), 64'(q.size() != 0));
            check("rnd_ready", 64'(oReady), 64'(q.size() < 2));
            if (oValid && q.size() != 0) begin
                check("rnd_data", 64'(oData), 64'(q[0]));
                check("rnd_syndrome", 64'(syndrome(oData)), 64'd0);
                check("rnd_flip", 64'(flip_faults(oData)), 64'd0);
            end
            iv = stream ? 1'b1 : ($urandom_range(0, 99) < pv);
            ir = stream ? 1'b1 : ($urandom_range(0, 99) < pr);
            d = DATA_W'($urandom);
            iValid = iv;
            iReady = ir;
            iData  = d;
            do_pop  = (q.size() != 0) && ir;
            do_push = iv && (q.size() < 2);
            if (do_pop) begin
                void'(q.pop_front());
                popped++;
            end
            if (do_push) q.push_back(ref_encode(d));
        end
    endtask

    typedef struct {
        logic [DATA_W-1:0] din;
        logic [CODE_W-1:0] exp;
    } vec_t;

    vec_t vecs[3];

    initial begin
        errors = 0;
        checks = 0;
        popped = 0;
        rst    = 1'b0;
        iValid = 1'b0;
        iReady = 1'b0;
        iData  = '0;

        vecs[0].din = 16'h443D;
        vecs[0].exp = CODE_W'(22'h08C3E6);
        vecs[1].din = 16'h0001;
`ifdef HAMMING_SECDED_EN
        vecs[1].exp = CODE_W'(22'h200007);
`else
        vecs[1].exp = CODE_W'(22'h000007);
`endif
        vecs[2].din = 16'h0000;
        vecs[2].exp = '0;

        repeat (2) @(negedge clk);
        check("reset_valid", 64'(oValid), 64'd0);
        check("reset_ready", 64'(oReady), 64'd0);
        check("reset_data", 64'(oData), 64'd0);
        rst = 1'b1;
        #1;
        check("release_ready", 64'(oReady), 64'd1);
        @(negedge clk);
        check("release_ready_next", 64'(oReady), 64'd1);
        check("release_valid", 64'(oValid), 64'd0);

        iReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iValid = 1'b1;
            iData  = vecs[i].din;
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), 64'(oValid), 64'd1);
            check($sformatf("vec%0d_data", i), 64'(oData), 64'(vecs[i].exp));
            iValid = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d_drained", i), 64'(oValid), 64'd0);
        end

        iReady = 1'b0;
        iValid = 1'b1;
        iData  = 16'h0001;
        @(negedge clk);
        check("bp_ready_one", 64'(oReady), 64'd1);
        iData = 16'h443D;
        @(negedge clk);
        check("bp_ready_full", 64'(oReady), 64'd0);
        check("bp_head", 64'(oData), 64'(vecs[1].exp));
        iData = 16'hAAAA;
        @(negedge clk);
        check("bp_hold_ready", 64'(oReady), 64'd0);
        check("bp_hold_data", 64'(oData), 64'(vecs[1].exp));
        iValid = 1'b0;
        iReady = 1'b1;
        @(negedge clk);
        check("bp_second_valid", 64'(oValid), 64'd1);
        check("bp_second_data", 64'(oData), 64'(vecs[0].exp));
        check("bp_ready_again", 64'(oReady), 64'd1);
        @(negedge clk);
        check("bp_empty", 64'(oValid), 64'd0);

        iReady = 1'b0;
        iValid = 1'b1;
        iData  = 16'h1234;
        @(negedge clk);
        iData = 16'h5678;
        @(negedge clk);
        check("rstmid_full", 64'(oReady), 64'd0);
        iValid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rstmid_valid", 64'(oValid), 64'd0);
        check("rstmid_ready", 64'(oReady), 64'd0);
        check("rstmid_data", 64'(oData), 64'd0);
        @(negedge clk);
        rst    = 1'b1;
        iReady = 1'b1;
        iValid = 1'b1;
        iData  = 16'hBEEF;
        @(negedge clk);
        check("rstmid_first_valid", 64'(oValid), 64'd1);
        check("rstmid_first_data", 64'(oData), 64'(ref_encode(16'hBEEF)));
        iValid = 1'b0;
        @(negedge clk);
        check("rstmid_empty", 64'(oValid), 64'd0);

        q.delete();
        popped = 0;
        run_random(100, 100, 100, 1'b1);
        run_random(3, 0, 100, 1'b0);
        check("stream_count", 64'(popped), 64'd100);

        run_random(400, 60, 50, 1'b0);
        run_random(4, 0, 100, 1'b0);
        check("final_empty", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
